// File: rtl/sync_fifo_counter_p.sv
// Single-clock FIFO with occupancy counter, almost flags, sticky errors and registered read port.
// Optional per-word even parity with read-side check when SYNC_FIFO_PARITY_EN is defined.
module sync_fifo_counter_p #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_enable,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
`ifdef SYNC_FIFO_PARITY_EN
  output logic                  underflow,
  output logic                  r_parity_err
`else
  output logic                  underflow
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
`ifdef SYNC_FIFO_PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif

  logic [MEM_W-1:0]      mem [DEPTH];
  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;
  logic                  wr_acc, rd_acc;

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  perr_q, perr_d;

`ifdef SYNC_FIFO_PARITY_EN
  assign wr_word = {^w_data, w_data};
`else
  assign wr_word = w_data;
`endif
  assign rd_word = mem[r_ptr_q];

  // Full/empty come from registered state, so a write at full is refused even alongside a read.
  assign wr_acc = w_enable & ~full_q  & ~clear;
  assign rd_acc = r_enable & ~empty_q & ~clear;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    r_data_d    = r_data_q;
    r_valid_d   = 1'b0;
    overflow_d  = overflow_q | (w_enable & full_q & ~clear);
    underflow_d = underflow_q | (r_enable & empty_q & ~clear);
    perr_d      = 1'b0;
    if (clear) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) begin
        r_ptr_d   = r_ptr_q + ADDR_WIDTH'(1);
        r_data_d  = rd_word[DATA_WIDTH-1:0];
        r_valid_d = 1'b1;
        perr_d    = ^rd_word;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Flags registered from next count so they track count with no extra latency.
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CNT_W'(AF_THRESH));
    ae_d    = (count_d <= CNT_W'(AE_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      r_data_q    <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= (AF_THRESH == 0);
      ae_q        <= 1'b1;
      perr_q      <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      r_data_q    <= r_data_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      perr_q      <= perr_d;
    end
  end

  // Storage is intentionally not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr_q] <= wr_word;
  end

  assign r_data       = r_data_q;
  assign r_valid      = r_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
`ifdef SYNC_FIFO_PARITY_EN
  assign r_parity_err = perr_q;
`endif

endmodule
